// File: rtl/ascii_cmd_rx.sv
// rtl/ascii_cmd_rx.sv - line-oriented ASCII command receiver fed by a UART byte strobe
//
// Collects bytes into a line buffer until '\n', then decodes one of
//   "RUN", "STOP", "CLR", "SET HH:MM:SS"
// and emits exactly one registered result pulse per non-empty line.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous reset, active low
//   rx_done    one-cycle strobe: rx_data holds a received byte
//   rx_data    received byte, valid only with rx_done
//   cmd_run    pulse: "RUN" accepted
//   cmd_stop   pulse: "STOP" accepted
//   cmd_clear  pulse: "CLR" accepted
//   cmd_set    pulse: valid "SET HH:MM:SS" accepted
//   cmd_err    pulse: line rejected (unknown, malformed, range, overflow, timeout)
//   set_hour   hour of last accepted SET (0-23)
//   set_min    minute of last accepted SET (0-59)
//   set_sec    second of last accepted SET (0-59)
//   rx_active  high while a partial line is held (collecting or discarding)
module ascii_cmd_rx #(
  parameter int TIMEOUT_CYC = 100_000_000,
  parameter int MAX_LEN     = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_done,
  input  logic [7:0] rx_data,
  output logic       cmd_run,
  output logic       cmd_stop,
  output logic       cmd_clear,
  output logic       cmd_set,
  output logic       cmd_err,
  output logic [4:0] set_hour,
  output logic [5:0] set_min,
  output logic [5:0] set_sec,
  output logic       rx_active
);

  // The buffer is never narrower than the longest command so the fixed
  // SET field positions always exist, even for a small MAX_LEN.
  localparam int BUF_LEN = (MAX_LEN > 12) ? MAX_LEN : 12;
  localparam int CW      = $clog2(BUF_LEN + 1);
  localparam int TW      = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  localparam logic [CW-1:0] LEN_MAX  = CW'(MAX_LEN);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_COLON = 8'h3A;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECV,
    S_DISCARD,
    S_EXEC
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            ovf_q, ovf_d;
  logic [7:0]      line_q [BUF_LEN];

  logic            wr_en;
  logic            clr_line;
  logic            run_d, stop_d, clear_d, set_d, err_d;
  logic [4:0]      hour_d;
  logic [5:0]      min_d, sec_d;
  logic            active_d;

  logic            is_lf, is_char;

  // '\r' is neither a terminator nor a payload character: it only counts
  // as activity for the inter-byte timeout.
  assign is_lf   = rx_done && (rx_data == CH_LF);
  assign is_char = rx_done && (rx_data != CH_LF) && (rx_data != CH_CR);

  // ---------------------------------------------------------------------
  // Line decode, evaluated from the buffer while in EXEC
  // ---------------------------------------------------------------------
  function automatic logic is_digit(input logic [7:0] c);
    return (c >= 8'h30) && (c <= 8'h39);
  endfunction

  function automatic logic [6:0] two_digit(input logic [3:0] tens, input logic [3:0] units);
    return 7'(tens) * 7'd10 + 7'(units);
  endfunction

  logic       match_run, match_stop, match_clr;
  logic       set_shape, set_ok;
  logic [6:0] hour_v, min_v, sec_v;

  assign match_run  = (count_q == CW'(3)) &&
                      ({line_q[0], line_q[1], line_q[2]} == "RUN");
  assign match_stop = (count_q == CW'(4)) &&
                      ({line_q[0], line_q[1], line_q[2], line_q[3]} == "STOP");
  assign match_clr  = (count_q == CW'(3)) &&
                      ({line_q[0], line_q[1], line_q[2]} == "CLR");

  assign set_shape  = (count_q == CW'(12)) &&
                      ({line_q[0], line_q[1], line_q[2], line_q[3]} == "SET ") &&
                      (line_q[6] == CH_COLON) && (line_q[9] == CH_COLON) &&
                      is_digit(line_q[4])  && is_digit(line_q[5])  &&
                      is_digit(line_q[7])  && is_digit(line_q[8])  &&
                      is_digit(line_q[10]) && is_digit(line_q[11]);

  // Digit low nibbles are the numeric value once set_shape has proven
  // the characters are '0'-'9'.
  assign hour_v = two_digit(line_q[4][3:0],  line_q[5][3:0]);
  assign min_v  = two_digit(line_q[7][3:0],  line_q[8][3:0]);
  assign sec_v  = two_digit(line_q[10][3:0], line_q[11][3:0]);

  assign set_ok = set_shape && (hour_v <= 7'd23) && (min_v <= 7'd59) && (sec_v <= 7'd59);

  // ---------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    tmo_d    = tmo_q;
    ovf_d    = ovf_q;
    wr_en    = 1'b0;
    clr_line = 1'b0;
    run_d    = 1'b0;
    stop_d   = 1'b0;
    clear_d  = 1'b0;
    set_d    = 1'b0;
    err_d    = 1'b0;
    hour_d   = set_hour;
    min_d    = set_min;
    sec_d    = set_sec;

    case (state_q)
      S_IDLE: begin
        tmo_d = '0;
        ovf_d = 1'b0;
        // A bare '\n' here is an empty line and is silently ignored.
        if (is_char) begin
          wr_en   = 1'b1;
          count_d = CW'(1);
          state_d = S_RECV;
        end
      end

      S_RECV, S_DISCARD: begin
        if (rx_done) begin
          tmo_d = '0;
          if (is_lf) begin
            // Overflowed lines also pass through EXEC so their error pulse
            // lands on the same cycle as a decoded result would.
            state_d = S_EXEC;
            ovf_d   = (state_q == S_DISCARD);
          end else if (is_char && (state_q == S_RECV)) begin
            if (count_q == LEN_MAX) begin
              state_d = S_DISCARD;
            end else begin
              wr_en   = 1'b1;
              count_d = count_q + CW'(1);
            end
          end
        end else if (tmo_q == TMO_LAST) begin
          err_d    = 1'b1;
          state_d  = S_IDLE;
          count_d  = '0;
          tmo_d    = '0;
          clr_line = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      S_EXEC: begin
        // Any rx_done arriving in this single cycle is dropped.
        state_d = S_IDLE;
        count_d = '0;
        tmo_d   = '0;
        ovf_d   = 1'b0;
        if (ovf_q) begin
          err_d = 1'b1;
        end else if (match_run) begin
          run_d = 1'b1;
        end else if (match_stop) begin
          stop_d = 1'b1;
        end else if (match_clr) begin
          clear_d = 1'b1;
        end else if (set_ok) begin
          set_d  = 1'b1;
          hour_d = hour_v[4:0];
          min_d  = min_v[5:0];
          sec_d  = sec_v[5:0];
        end else begin
          err_d = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        count_d = '0;
        tmo_d   = '0;
        ovf_d   = 1'b0;
      end
    endcase

    active_d = (state_d == S_RECV) || (state_d == S_DISCARD);
  end

  // ---------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      tmo_q     <= '0;
      ovf_q     <= 1'b0;
      cmd_run   <= 1'b0;
      cmd_stop  <= 1'b0;
      cmd_clear <= 1'b0;
      cmd_set   <= 1'b0;
      cmd_err   <= 1'b0;
      set_hour  <= '0;
      set_min   <= '0;
      set_sec   <= '0;
      rx_active <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      tmo_q     <= tmo_d;
      ovf_q     <= ovf_d;
      cmd_run   <= run_d;
      cmd_stop  <= stop_d;
      cmd_clear <= clear_d;
      cmd_set   <= set_d;
      cmd_err   <= err_d;
      set_hour  <= hour_d;
      set_min   <= min_d;
      set_sec   <= sec_d;
      rx_active <= active_d;
    end
  end

  // Line buffer; wr_en is only raised while count_q < MAX_LEN.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < BUF_LEN; i++) begin
        line_q[i] <= '0;
      end
    end else if (clr_line) begin
      for (int i = 0; i < BUF_LEN; i++) begin
        line_q[i] <= '0;
      end
    end else if (wr_en) begin
      line_q[count_q] <= rx_data;
    end
  end

endmodule

// File: tb/tb_ascii_cmd_rx.sv
// tb/tb_ascii_cmd_rx.sv - self-checking bench for ascii_cmd_rx
module tb_ascii_cmd_rx;

  localparam int TMO  = 50;
  localparam int MAXL = 12;

  localparam logic [4:0] E_NONE = 5'b00000;
  localparam logic [4:0] E_RUN  = 5'b10000;
  localparam logic [4:0] E_STOP = 5'b01000;
  localparam logic [4:0] E_CLR  = 5'b00100;
  localparam logic [4:0] E_SET  = 5'b00010;
  localparam logic [4:0] E_ERR  = 5'b00001;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_done = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       cmd_run, cmd_stop, cmd_clear, cmd_set, cmd_err;
  logic [4:0] set_hour;
  logic [5:0] set_min, set_sec;
  logic       rx_active;

  ascii_cmd_rx #(.TIMEOUT_CYC(TMO), .MAX_LEN(MAXL)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_done   (rx_done),
    .rx_data   (rx_data),
    .cmd_run   (cmd_run),
    .cmd_stop  (cmd_stop),
    .cmd_clear (cmd_clear),
    .cmd_set   (cmd_set),
    .cmd_err   (cmd_err),
    .set_hour  (set_hour),
    .set_min   (set_min),
    .set_sec   (set_sec),
    .rx_active (rx_active)
  );

  always #5 clk = ~clk;

  wire [4:0] cmds = {cmd_run, cmd_stop, cmd_clear, cmd_set, cmd_err};

  int vectors     = 0;
  int miscompares = 0;
  int pending     = 0;
  int exp_h       = 0;
  int exp_m       = 0;
  int exp_s       = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: what a whole line (without '\r' and '\n') must produce.
  task automatic model_line(input string s, output logic [4:0] e);
    int n, h, m, sc;
    bit ok;
    int pos [6];
    pos = '{4, 5, 7, 8, 10, 11};
    n = s.len();
    e = E_NONE;
    if (n > 0) begin
      e = E_ERR;
      if (n <= MAXL) begin
        if (s == "RUN") e = E_RUN;
        else if (s == "STOP") e = E_STOP;
        else if (s == "CLR") e = E_CLR;
        else if (n == 12 && s.substr(0, 3) == "SET " && s[6] == ":" && s[9] == ":") begin
          ok = 1'b1;
          foreach (pos[k]) if (!(s[pos[k]] >= "0" && s[pos[k]] <= "9")) ok = 1'b0;
          if (ok) begin
            h  = (int'(s[4]) - 48) * 10 + (int'(s[5]) - 48);
            m  = (int'(s[7]) - 48) * 10 + (int'(s[8]) - 48);
            sc = (int'(s[10]) - 48) * 10 + (int'(s[11]) - 48);
            if (h <= 23 && m <= 59 && sc <= 59) begin
              e = E_SET;
              exp_h = h;
              exp_m = m;
              exp_s = sc;
            end
          end
        end
      end
    end
  endtask

  task automatic idle_cycle();
    tick();
    chk("idle_cmds", cmds, E_NONE);
    chk("idle_active", rx_active, pending > 0);
  endtask

  task automatic put_byte(input logic [7:0] b);
    rx_done = 1'b1;
    rx_data = b;
    tick();
    rx_done = 1'b0;
    rx_data = 8'($urandom);
    if (b != 8'h0D) pending++;
    chk("byte_cmds", cmds, E_NONE);
    chk("byte_active", rx_active, pending > 0);
  endtask

  task automatic send_line(input string s, input int maxgap, input bit noise);
    logic [4:0] e;
    model_line(s, e);
    for (int i = 0; i < s.len(); i++) begin
      repeat ($urandom_range(0, maxgap)) idle_cycle();
      if (noise && $urandom_range(0, 7) == 0) put_byte(8'h0D);
      put_byte(s[i]);
    end
    if (noise) put_byte(8'h0D);
    repeat ($urandom_range(0, maxgap)) idle_cycle();
    rx_done = 1'b1;
    rx_data = 8'h0A;
    tick();
    rx_done = 1'b0;
    pending = 0;
    chk("lf+1_cmds", cmds, E_NONE);
    chk("lf+1_active", rx_active, 0);
    tick();
    chk({"pulse:", s}, cmds, e);
    chk("pulse_hour", set_hour, exp_h);
    chk("pulse_min", set_min, exp_m);
    chk("pulse_sec", set_sec, exp_s);
    tick();
    chk("after_pulse_cmds", cmds, E_NONE);
    chk("hold_hour", set_hour, exp_h);
  endtask

  function automatic string rand_line();
    string alpha, s;
    int kind;
    alpha = "RUNSTOPCLE :0123456789X";
    kind  = $urandom_range(0, 7);
    s     = "";
    case (kind)
      0: s = "RUN";
      1: s = "STOP";
      2: s = "CLR";
      3: s = $sformatf("SET %02d:%02d:%02d", $urandom_range(0, 23),
                       $urandom_range(0, 59), $urandom_range(0, 59));
      4: s = $sformatf("SET %02d:%02d:%02d", $urandom_range(0, 99),
                       $urandom_range(0, 99), $urandom_range(0, 99));
      5: begin
        int n = $urandom_range(1, 16);
        for (int i = 0; i < n; i++)
          s = $sformatf("%s%c", s, alpha[$urandom_range(0, alpha.len() - 1)]);
      end
      6: case ($urandom_range(0, 6))
        0: s = "run";
        1: s = "RUNX";
        2: s = "STO";
        3: s = "CLR ";
        4: s = "SET 12-00-00";
        5: s = "SET 1:00:00";
        default: s = "";
      endcase
      default: begin
        s = $sformatf("SET %02d:%02d:%02d", $urandom_range(0, 23),
                      $urandom_range(0, 59), $urandom_range(0, 59));
        s.putc($urandom_range(0, 11), alpha[$urandom_range(0, alpha.len() - 1)]);
      end
    endcase
    return s;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int edges;

    // Reset state
    repeat (3) tick();
    chk("rst_cmds", cmds, E_NONE);
    chk("rst_active", rx_active, 0);
    chk("rst_hour", set_hour, 0);
    chk("rst_min", set_min, 0);
    chk("rst_sec", set_sec, 0);

    // First byte right on the first edge after release, with CR noise
    rst = 1'b1;
    send_line("RUN", 0, 1'b1);

    send_line("SET 23:59:07", 2, 1'b0);
    send_line("SET 24:00:00", 2, 1'b0);
    send_line("ABCDEFGHIJKLMN", 1, 1'b0);
    send_line("STOP", 1, 1'b0);
    send_line("", 1, 1'b0);
    send_line("run", 1, 1'b0);
    send_line("SET 00:00:00", 1, 1'b0);
    send_line("SET 23:59:59", 1, 1'b0);
    send_line("SET 12:60:00", 1, 1'b0);
    send_line("SET 12:00:60", 1, 1'b0);
    send_line("SET 1a:00:00", 1, 1'b0);
    send_line("ABCDEFGHIJKL", 1, 1'b0);
    send_line("ABCDEFGHIJKLM", 1, 1'b0);
    send_line("CLR", 3, 1'b1);

    // Inter-byte timeout
    put_byte("C");
    put_byte("L");
    edges = 0;
    while (cmds == E_NONE && edges < 60) begin
      tick();
      edges++;
    end
    pending = 0;
    chk("tmo_latency_window", (edges >= 49) && (edges <= 51), 1);
    chk("tmo_cmds", cmds, E_ERR);
    chk("tmo_active", rx_active, 0);
    tick();
    chk("tmo_after_cmds", cmds, E_NONE);
    send_line("CLR", 2, 1'b0);

    // Asynchronous reset mid-line
    send_line("SET 05:06:07", 1, 1'b0);
    put_byte("S");
    put_byte("E");
    put_byte("T");
    put_byte(" ");
    put_byte("1");
    #2;
    rst = 1'b0;
    #1;
    pending = 0;
    exp_h = 0;
    exp_m = 0;
    exp_s = 0;
    chk("arst_cmds", cmds, E_NONE);
    chk("arst_active", rx_active, 0);
    chk("arst_hour", set_hour, 0);
    chk("arst_min", set_min, 0);
    chk("arst_sec", set_sec, 0);
    tick();
    tick();
    rst = 1'b1;
    repeat (4) idle_cycle();
    send_line("RUN", 1, 1'b0);

    // Randomized lines
    for (int i = 0; i < 200; i++) begin
      send_line(rand_line(), 3, $urandom_range(0, 3) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
